f_cvt_seq: RTL
==============

Name: f_cvt_seq

Overview:
- Multi-cycle, IEEE-754-compliant single-precision float <-> 32-bit integer converter for the floating ALU.
- Covers FCVT.W.S, FCVT.WU.S, FCVT.S.W and FCVT.S.WU.
- Adds all five rounding modes, saturation and fflags.
- Uses a 1-bit/cycle iterative normaliser for area; start/done handshake toward the FP issue logic.

Parameters:
- FLEN, 32, operand/result width (only 32 supported)
- EXP_BIAS, 127, single-precision exponent bias

Ports:
- CLK  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Start  in  1  request; accepted only in IDLE
- Rs1  in  FLEN  source operand (float bits or integer)
- Rs2_0  in  1  signedness select: 0 = signed, 1 = unsigned
- Funct7_3  in  1  direction: 0 = float->int, 1 = int->float
- Rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle pulse; Result/Fflags valid
- Result  out  FLEN  converted value, held until next Done
- Fflags  out  5  {NV,DZ,OF,UF,NX}, held with Result; DZ/OF/UF always 0

Behaviour:
- Reset (async, any state): state=IDLE; Busy=0, Done=0, Result=0, Fflags=0; in-flight operation discarded.
- Op = {Funct7_3,Rs2_0}: 00 W.S, 01 WU.S, 10 S.W, 11 S.WU. Operands and Rm captured on accepted Start.
- Start while Busy=1 is ignored, with no effect on the in-flight op.
- FSM: IDLE -> NORM (k>0 shifts) or ROUND (k=0) or DONE (special case); NORM -> ROUND when the shift count is exhausted; ROUND -> DONE; DONE -> IDLE.
- Done=1 only in DONE. Result and Fflags are registered on entry to DONE.
- Latency Start->Done: k+2 cycles for normal ops; 1 cycle for special cases.
- Reserved Rm (101-111): special case. Result=0, Fflags=NV.
- Int->float:
  - mag = |Rs1| for S.W (0x80000000 -> 2^31); mag = Rs1 for S.WU.
  - mag=0: special case, Result=0x00000000, flags 0.
  - NORM shifts mag left 1 bit/cycle until bit31=1; k = leading-zero count (0..31).
  - exp = 158-k; mant = mag[30:8]; guard = mag[7]; sticky = |mag[6:0].
  - Rounding carry out of mant increments exp (mant becomes 0). NX = guard|sticky. Sign = Rs1[31] only for S.W.
- Float->int:
  - Unpack e, f. sig = {e!=0, f}; E = e-127.
  - NaN (e=255, f!=0) or +inf: special case. Result 0x7FFFFFFF (W) / 0xFFFFFFFF (WU), NV.
  - -inf: special case. Result 0x80000000 (W) / 0x00000000 (WU), NV.
  - E>=32: special case. Same saturation as inf of that sign, NV.
  - Otherwise 32-bit working mag = sig, plus guard and sticky:
    - E>23: k = E-23 left shifts.
    - E<23: k = min(23-E, 26) right shifts; each shifts guard into sticky and LSB into guard.
    - Zero/subnormal inputs follow the right-shift path.
  - ROUND: 33-bit rounded magnitude.
  - Range rules:
    - W positive and mag>0x7FFFFFFF -> 0x7FFFFFFF, NV.
    - W negative and mag>0x80000000 -> 0x80000000, NV.
    - WU negative and mag!=0 -> 0, NV.
    - WU mag>0xFFFFFFFF -> 0xFFFFFFFF, NV.
    - Otherwise Result = sign ? -mag : mag.
  - NX = (guard|sticky) && !NV. -0.4 under WU rounding to 0 gives Result 0, NX only.
- Rounding increment uses sign, LSB, guard, sticky:
  - RNE: g&(s|lsb)
  - RTZ: 0
  - RDN: sign&(g|s)
  - RUP: !sign&(g|s)
  - RMM: g

Decomposition:
- Package f_cvt_pkg holds:
  - op encodings
  - Rm encodings
  - fflag bit indices
  - EXP_BIAS
  - saturation constants (0x7FFFFFFF, 0x80000000, 0xFFFFFFFF)
  - FSM state enum
- One combinational sub-module f_round_inc (inputs rm, sign, lsb, guard, sticky; output inc), reusable by later FP units.

Test Plan:
- S.W Rs1=0x00000001, RNE -> Result 0x3F800000, Fflags 0, Done exactly 33 cycles after Start.
- S.WU Rs1=0xFFFFFFFF, RNE -> 0x4F800000, NX, latency 2. Same with RTZ -> 0x4F7FFFFF, NX. S.W 0x80000000 -> 0xCF000000, flags 0.
- W.S rounding:
  - 0x3FC00000 (1.5): RNE -> 2, RTZ -> 1, both NX.
  - 0x40200000 (2.5): RNE -> 2.
  - 0xBFC00000 (-1.5): RDN -> 0xFFFFFFFE, RMM -> 0xFFFFFFFE.
- Saturation/specials:
  - W.S 0x4F000000 -> 0x7FFFFFFF, NV.
  - W.S 0xCF000000 -> 0x80000000, flags 0.
  - WU.S 0xBF800000 -> 0, NV.
  - WU.S 0x7FC00000 -> 0xFFFFFFFF, NV, Done 1 cycle after Start.
- Control:
  - Second Start during Busy is ignored; only one Done occurs, carrying the first result.
  - Rm=101 -> Result 0, NV.
  - rst_n low mid-NORM -> Busy/Done/Result/Fflags 0 immediately; a new Start after release completes normally.

Source files
------------

// File: rtl/f_cvt_seq_pkg.sv
// Shared encodings and constants for the float <-> int32 converter.
package f_cvt_pkg;

   localparam logic [1:0] OP_W_S  = 2'b00;
   localparam logic [1:0] OP_WU_S = 2'b01;
   localparam logic [1:0] OP_S_W  = 2'b10;
   localparam logic [1:0] OP_S_WU = 2'b11;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   localparam int FLG_NV = 4;
   localparam int FLG_DZ = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   localparam int EXP_BIAS = 127;

   localparam logic [31:0] SAT_W_POS  = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_W_NEG  = 32'h8000_0000;
   localparam logic [31:0] SAT_WU_POS = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_e;

   // Saturated float->int result for an out-of-range value of the given sign.
   function automatic logic [31:0] f2i_sat(input logic uns, input logic neg);
      if (uns) return neg ? 32'h0 : SAT_WU_POS;
      return neg ? SAT_W_NEG : SAT_W_POS;
   endfunction

endpackage

// File: rtl/f_cvt_seq_if.sv
// Request/response bundle between FP issue logic and the converter.
interface f_cvt_seq_if #(parameter int FLEN = 32);
   logic            Start;
   logic [FLEN-1:0] Rs1;
   logic            Rs2_0;
   logic            Funct7_3;
   logic [2:0]      Rm;
   logic            Busy;
   logic            Done;
   logic [FLEN-1:0] Result;
   logic [4:0]      Fflags;

   modport master (output Start, Rs1, Rs2_0, Funct7_3, Rm,
                   input  Busy, Done, Result, Fflags);
   modport slave  (input  Start, Rs1, Rs2_0, Funct7_3, Rm,
                   output Busy, Done, Result, Fflags);
endinterface

// File: rtl/f_cvt_seq_round_inc.sv
// Round-increment decision from sign, LSB, guard and sticky for all IEEE modes.
module f_round_inc
   import f_cvt_pkg::*;
(
   input  logic [2:0] rm,
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   output logic       inc
);
   always_comb begin
      inc = 1'b0;
      case (rm)
         RM_RNE:  inc = guard & (sticky | lsb);
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = 1'b0;
      endcase
   end
endmodule

// File: rtl/f_cvt_seq.sv
// Iterative float <-> int32 converter: one shift per cycle in NORM, then a
// single rounding/range-check cycle before the Done pulse.
module f_cvt_seq #(
   parameter int FLEN     = 32,
   parameter int EXP_BIAS = 127
) (
   input  logic        CLK,
   input  logic        rst_n,
   f_cvt_seq_if.slave  io
);
   import f_cvt_pkg::*;

   // Exponent landmarks: int->float starts at 2^31, float->int has its
   // binary point at bit 0 when E == 23, and saturates from E == 32.
   localparam logic [7:0] E_I2F = 8'(EXP_BIAS + 31);
   localparam logic [7:0] E_RSH = 8'(EXP_BIAS + 23);
   localparam logic [7:0] E_SAT = 8'(EXP_BIAS + 32);

   state_e          state_q, state_d;
   logic            i2f_q, i2f_d, uns_q, uns_d, sign_q, sign_d, left_q, left_d;
   logic [2:0]      rm_q, rm_d;
   logic [FLEN-1:0] mag_q, mag_d, result_q, result_d;
   logic            guard_q, guard_d, sticky_q, sticky_d;
   logic [4:0]      cnt_q, cnt_d, fflags_q, fflags_d;
   logic [7:0]      exp_q, exp_d;

   logic [31:0] imag;
   logic [7:0]  ue, ediff, rsh;
   logic [23:0] mant_sum;
   logic [32:0] mag33;
   logic        nv, rnd_lsb, rnd_g, rnd_s, rnd_inc;

   assign rnd_lsb = i2f_q ? mag_q[8] : mag_q[0];
   assign rnd_g   = i2f_q ? mag_q[7] : guard_q;
   assign rnd_s   = i2f_q ? |mag_q[6:0] : sticky_q;

   f_round_inc u_round (
      .rm(rm_q), .sign(sign_q), .lsb(rnd_lsb), .guard(rnd_g), .sticky(rnd_s), .inc(rnd_inc)
   );

   always_comb begin
      state_d = state_q;  i2f_d = i2f_q;  uns_d = uns_q;  rm_d = rm_q;
      sign_d = sign_q;  left_d = left_q;  mag_d = mag_q;  guard_d = guard_q;
      sticky_d = sticky_q;  cnt_d = cnt_q;  exp_d = exp_q;
      result_d = result_q;  fflags_d = fflags_q;
      imag = '0;  ue = io.Rs1[30:23];  ediff = ue - E_RSH;  rsh = E_RSH - ue;
      mant_sum = '0;  mag33 = '0;  nv = 1'b0;
      case (state_q)
         S_IDLE: if (io.Start) begin
            i2f_d = io.Funct7_3;  uns_d = io.Rs2_0;  rm_d = io.Rm;
            guard_d = 1'b0;  sticky_d = 1'b0;  left_d = 1'b0;
            cnt_d = '0;  exp_d = E_I2F;
            if (io.Rm > RM_RMM) begin
               state_d = S_DONE;  result_d = '0;  fflags_d = 5'b1 << FLG_NV;
            end else if (io.Funct7_3) begin
               sign_d = ~io.Rs2_0 & io.Rs1[31];
               imag   = (~io.Rs2_0 & io.Rs1[31]) ? (~io.Rs1 + 32'd1) : io.Rs1;
               mag_d  = imag;
               if (imag == 32'd0) begin
                  state_d = S_DONE;  result_d = '0;  fflags_d = '0;
               end else begin
                  state_d = imag[31] ? S_ROUND : S_NORM;
               end
            end else begin
               sign_d = io.Rs1[31];
               mag_d  = {8'd0, ue != 8'd0, io.Rs1[22:0]};
               if (ue == 8'hFF && io.Rs1[22:0] != 23'd0) begin
                  state_d = S_DONE;  result_d = f2i_sat(io.Rs2_0, 1'b0);
                  fflags_d = 5'b1 << FLG_NV;
               end else if (ue >= E_SAT) begin
                  state_d = S_DONE;  result_d = f2i_sat(io.Rs2_0, io.Rs1[31]);
                  fflags_d = 5'b1 << FLG_NV;
               end else if (ue > E_RSH) begin
                  left_d = 1'b1;  cnt_d = ediff[4:0];  state_d = S_NORM;
               end else if (ue < E_RSH) begin
                  cnt_d = (rsh > 8'd26) ? 5'd26 : rsh[4:0];  state_d = S_NORM;
               end else begin
                  state_d = S_ROUND;
               end
            end
         end
         S_NORM: begin
            if (i2f_q) begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 8'd1;
               if (mag_q[30]) state_d = S_ROUND;
            end else begin
               if (left_q) begin
                  mag_d = mag_q << 1;
               end else begin
                  mag_d    = mag_q >> 1;
                  guard_d  = mag_q[0];
                  sticky_d = sticky_q | guard_q;
               end
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            state_d  = S_DONE;
            fflags_d = '0;
            if (i2f_q) begin
               // A carry out of the mantissa wraps it to zero and bumps the exponent.
               mant_sum = {1'b0, mag_q[30:8]} + {23'd0, rnd_inc};
               result_d = {sign_q, exp_q + {7'd0, mant_sum[23]}, mant_sum[22:0]};
               fflags_d[FLG_NX] = rnd_g | rnd_s;
            end else begin
               mag33 = {1'b0, mag_q} + {32'd0, rnd_inc};
               if (uns_q) nv = sign_q ? (mag33 != 33'd0) : mag33[32];
               else       nv = sign_q ? (mag33 > 33'h0_8000_0000) : (mag33 > 33'h0_7FFF_FFFF);
               if (nv)          result_d = f2i_sat(uns_q, sign_q);
               else if (sign_q) result_d = ~mag33[31:0] + 32'd1;
               else             result_d = mag33[31:0];
               fflags_d[FLG_NV] = nv;
               fflags_d[FLG_NX] = (rnd_g | rnd_s) & ~nv;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;  i2f_q <= 1'b0;  uns_q <= 1'b0;  rm_q <= '0;
         sign_q <= 1'b0;  left_q <= 1'b0;  mag_q <= '0;  guard_q <= 1'b0;
         sticky_q <= 1'b0;  cnt_q <= '0;  exp_q <= '0;
         result_q <= '0;  fflags_q <= '0;
      end else begin
         state_q <= state_d;  i2f_q <= i2f_d;  uns_q <= uns_d;  rm_q <= rm_d;
         sign_q <= sign_d;  left_q <= left_d;  mag_q <= mag_d;  guard_q <= guard_d;
         sticky_q <= sticky_d;  cnt_q <= cnt_d;  exp_q <= exp_d;
         result_q <= result_d;  fflags_q <= fflags_d;
      end
   end

   assign io.Busy   = (state_q != S_IDLE);
   assign io.Done   = (state_q == S_DONE);
   assign io.Result = result_q;
   assign io.Fflags = fflags_q;

endmodule
